// File: rtl/uart_transmitter_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_transmitter_if
// Description : Byte handshake between a producer (e.g. RS decoder output)
//               and the UART transmitter. A byte moves on every rising clock
//               edge where tx_valid && tx_ready.
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_transmitter_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    // Producer side: offers bytes, observes back-pressure
    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready
    );

    // Transmitter side: accepts bytes, signals FIFO space
    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready
    );
endinterface
`default_nettype wire

// File: rtl/uart_transmitter.sv
`default_nettype none
// ============================================================================
// Module      : uart_transmitter
// Description : Byte FIFO plus UART serialiser. Frame is start(0), 8 data
//               bits LSB first, optional even-parity bit, stop(1). Tx_D is
//               driven straight from a flop. Frames from a non-empty FIFO
//               follow each other with no idle gap.
//               Build option: define UART_TX_PARITY_EN to include the parity
//               bit (11-bit frame); leave it undefined for a 10-bit frame.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_transmitter #(
    parameter int CLKS_PER_BIT = 864,   // clk cycles per line bit, >= 2
    parameter int FIFO_DEPTH   = 4      // power of 2, >= 2
) (
    input  logic                             clk,
    input  logic                             reset,      // synchronous, active low
    uart_transmitter_if.slave                tx_if,
    output logic                             Tx_D,
    output logic                             tx_busy,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_count
);

    localparam int c_CLK_W = $clog2(CLKS_PER_BIT);
    localparam int c_PTR_W = $clog2(FIFO_DEPTH);
    localparam int c_CNT_W = $clog2(FIFO_DEPTH + 1);

    localparam logic [c_CLK_W-1:0] c_LAST_TICK = c_CLK_W'(CLKS_PER_BIT - 1);
    localparam logic [c_CNT_W-1:0] c_FULL      = c_CNT_W'(FIFO_DEPTH);

    localparam logic [2:0] c_IDLE   = 3'd0;
    localparam logic [2:0] c_START  = 3'd1;
    localparam logic [2:0] c_DATA   = 3'd2;
`ifdef UART_TX_PARITY_EN
    localparam logic [2:0] c_PARITY = 3'd3;
`endif
    localparam logic [2:0] c_STOP   = 3'd4;

    // ------------------------------------------------------------------
    // Byte FIFO
    // ------------------------------------------------------------------
    logic [7:0]         r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic [c_CNT_W-1:0] w_count_nxt;
    logic               r_ready;
    logic               w_push;
    logic               w_pop;
    logic [7:0]         w_head;

    // tx_ready is registered, so a push while full is simply never accepted
    assign w_push = tx_if.tx_valid && r_ready;
    assign w_head = r_mem[r_rd_ptr];

    // Occupancy after this edge; push and pop together leave it unchanged
    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + 1'b1;
            2'b01:   w_count_nxt = r_count - 1'b1;
            default: w_count_nxt = r_count;
        endcase
    end

    // Storage only; tx_data is captured at push and never looked at again
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= tx_if.tx_data;
        end
    end

    // Pointers wrap naturally because FIFO_DEPTH is a power of 2
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ready  <= 1'b1;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= w_count_nxt;
            r_ready <= (w_count_nxt != c_FULL);
        end
    end

    // ------------------------------------------------------------------
    // Serialiser FSM
    // ------------------------------------------------------------------
    logic [2:0]         r_state,   w_state_nxt;
    logic               r_txd,     w_txd_nxt;
    logic               r_busy,    w_busy_nxt;
    logic [7:0]         r_shift,   w_shift_nxt;
    logic [2:0]         r_bit_idx, w_bit_idx_nxt;
    logic [c_CLK_W-1:0] r_clk_cnt, w_clk_cnt_nxt;
    logic               w_tick;
`ifdef UART_TX_PARITY_EN
    logic               r_parity,  w_parity_nxt;
`endif

    assign w_tick = (r_clk_cnt == c_LAST_TICK);

    // State and line flops; reset aborts any frame and returns the line high
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state   <= c_IDLE;
            r_txd     <= 1'b1;
            r_busy    <= 1'b0;
            r_shift   <= '0;
            r_bit_idx <= '0;
            r_clk_cnt <= '0;
`ifdef UART_TX_PARITY_EN
            r_parity  <= 1'b0;
`endif
        end else begin
            r_state   <= w_state_nxt;
            r_txd     <= w_txd_nxt;
            r_busy    <= w_busy_nxt;
            r_shift   <= w_shift_nxt;
            r_bit_idx <= w_bit_idx_nxt;
            r_clk_cnt <= w_clk_cnt_nxt;
`ifdef UART_TX_PARITY_EN
            r_parity  <= w_parity_nxt;
`endif
        end
    end

    // Next state and next line value; the line value is computed one edge
    // ahead so Tx_D comes straight off r_txd
    always_comb begin
        w_state_nxt   = r_state;
        w_txd_nxt     = r_txd;
        w_busy_nxt    = r_busy;
        w_shift_nxt   = r_shift;
        w_bit_idx_nxt = r_bit_idx;
        w_clk_cnt_nxt = w_tick ? '0 : r_clk_cnt + 1'b1;
        w_pop         = 1'b0;
`ifdef UART_TX_PARITY_EN
        w_parity_nxt  = r_parity;
`endif
        case (r_state)
            c_IDLE: begin
                w_clk_cnt_nxt = '0;
                w_txd_nxt     = 1'b1;
                w_busy_nxt    = 1'b0;
                if (r_count != '0) begin
                    w_pop       = 1'b1;
                    w_shift_nxt = w_head;
`ifdef UART_TX_PARITY_EN
                    w_parity_nxt = ^w_head;
`endif
                    w_state_nxt = c_START;
                    w_txd_nxt   = 1'b0;
                    w_busy_nxt  = 1'b1;
                end
            end

            c_START: begin
                if (w_tick) begin
                    w_state_nxt   = c_DATA;
                    w_txd_nxt     = r_shift[0];
                    w_bit_idx_nxt = '0;
                end
            end

            c_DATA: begin
                if (w_tick) begin
                    if (r_bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        w_state_nxt = c_PARITY;
                        w_txd_nxt   = r_parity;
`else
                        w_state_nxt = c_STOP;
                        w_txd_nxt   = 1'b1;
`endif
                    end else begin
                        w_shift_nxt   = {1'b0, r_shift[7:1]};
                        w_txd_nxt     = r_shift[1];
                        w_bit_idx_nxt = r_bit_idx + 1'b1;
                    end
                end
            end

`ifdef UART_TX_PARITY_EN
            c_PARITY: begin
                if (w_tick) begin
                    w_state_nxt = c_STOP;
                    w_txd_nxt   = 1'b1;
                end
            end
`endif

            c_STOP: begin
                if (w_tick) begin
                    if (r_count != '0) begin
                        // Back-to-back: next start bit follows the stop bit directly
                        w_pop       = 1'b1;
                        w_shift_nxt = w_head;
`ifdef UART_TX_PARITY_EN
                        w_parity_nxt = ^w_head;
`endif
                        w_state_nxt = c_START;
                        w_txd_nxt   = 1'b0;
                        w_busy_nxt  = 1'b1;
                    end else begin
                        w_state_nxt = c_IDLE;
                        w_txd_nxt   = 1'b1;
                        w_busy_nxt  = 1'b0;
                    end
                end
            end

            default: begin
                w_state_nxt   = c_IDLE;
                w_txd_nxt     = 1'b1;
                w_busy_nxt    = 1'b0;
                w_clk_cnt_nxt = '0;
            end
        endcase
    end

    assign tx_if.tx_ready = r_ready;
    assign Tx_D           = r_txd;
    assign tx_busy        = r_busy;
    assign fifo_count     = r_count;

endmodule
`default_nettype wire

// File: tb/tb_uart_transmitter.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_transmitter
// Description : Self-checking bench for uart_transmitter. Accepted bytes are
//               queued with their acceptance edge; a line monitor decodes
//               Tx_D cycle by cycle against frames built from those bytes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_transmitter;

    localparam int c_CPB   = 16;
    localparam int c_DEPTH = 4;
`ifdef UART_TX_PARITY_EN
    localparam int c_FRAME_BITS = 11;
`else
    localparam int c_FRAME_BITS = 10;
`endif
    localparam int c_FRAME_CYC = c_FRAME_BITS * c_CPB;

    logic       clk = 1'b0;
    logic       reset;
    logic       Tx_D;
    logic       tx_busy;
    logic [2:0] fifo_count;

    int checks    = 0;
    int errors    = 0;
    int cyc       = 0;
    int frames_rx = 0;

    logic [7:0] sb_data  [$];
    int         sb_stamp [$];

    uart_transmitter_if u_if ();

    uart_transmitter #(
        .CLKS_PER_BIT (c_CPB),
        .FIFO_DEPTH   (c_DEPTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .tx_if      (u_if),
        .Tx_D       (Tx_D),
        .tx_busy    (tx_busy),
        .fifo_count (fifo_count)
    );

    always #5 clk = ~clk;

    // Record every accepted byte with the edge that accepted it
    always @(posedge clk) begin
        if (!reset) begin
            sb_data.delete();
            sb_stamp.delete();
        end else if (u_if.tx_valid && u_if.tx_ready) begin
            sb_data.push_back(u_if.tx_data);
            sb_stamp.push_back(cyc + 1);
        end
        cyc <= cyc + 1;
    end

    // Line monitor: a queued byte must start on the edge after it is
    // visible to an idle transmitter, and every frame bit must hold its
    // value (with tx_busy high) for exactly c_CPB cycles
    initial begin : monitor
        logic       bits [0:10];
        logic [7:0] mb;
        logic       active;
        logic       bad;
        logic       due;
        int         pos;
        active = 1'b0;
        bad    = 1'b0;
        pos    = 0;
        mb     = '0;
        forever begin
            @(negedge clk);
            if (reset !== 1'b1) begin
                active = 1'b0;
                continue;
            end
            if (!active) begin
                due = (sb_data.size() > 0) && (sb_stamp[0] < cyc);
                if (due) begin
                    checks++;
                    if (Tx_D !== 1'b0) begin
                        errors++;
                        $display("FAIL start_latency: Tx_D=%0b at cycle %0d, required 0 (byte %02h accepted at cycle %0d)",
                                 Tx_D, cyc, sb_data[0], sb_stamp[0]);
                    end
                end
                if (Tx_D === 1'b0) begin
                    if (!due) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_frame: start bit at cycle %0d with no byte due", cyc);
                    end else begin
                        mb = sb_data.pop_front();
                        void'(sb_stamp.pop_front());
                        bits[0] = 1'b0;
                        for (int k = 0; k < 8; k++) bits[k+1] = mb[k];
`ifdef UART_TX_PARITY_EN
                        bits[9]  = ($countones(mb) % 2 == 1);
                        bits[10] = 1'b1;
`else
                        bits[9]  = 1'b1;
                        bits[10] = 1'b1;
`endif
                        active = 1'b1;
                        pos    = 0;
                        bad    = 1'b0;
                    end
                end
            end
            if (active) begin
                if (Tx_D !== bits[pos / c_CPB] || tx_busy !== 1'b1) bad = 1'b1;
                pos++;
                if (pos % c_CPB == 0) begin
                    checks++;
                    if (bad) begin
                        errors++;
                        $display("FAIL frame_bit: byte %02h bit %0d ended cycle %0d, line/busy wrong, required line %0b",
                                 mb, pos / c_CPB - 1, cyc, bits[pos / c_CPB - 1]);
                    end
                    bad = 1'b0;
                    if (pos == c_FRAME_CYC) begin
                        active = 1'b0;
                        frames_rx++;
                    end
                end
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end
    endtask

    // Returns at a negedge with the transmitter idle and FIFO empty
    task automatic wait_idle();
        int n;
        n = 0;
        while ((tx_busy !== 1'b0 || fifo_count !== 3'd0) && n < 20000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20000) check("idle_timeout", 1, 0);
    endtask

    // One byte into an idle transmitter, with latency and busy-window checks
    task automatic send_single(input logic [7:0] b);
        wait_idle();
        u_if.tx_valid = 1'b1;
        u_if.tx_data  = b;
        @(negedge clk);
        u_if.tx_valid = 1'b0;
        u_if.tx_data  = 8'($urandom);
        check("queued_count", int'(fifo_count), 1);
        check("pre_start_txd", int'(Tx_D), 1);
        @(negedge clk);
        check("start_txd", int'(Tx_D), 0);
        check("start_busy", int'(tx_busy), 1);
        check("start_count", int'(fifo_count), 0);
        repeat (c_FRAME_CYC - 1) @(negedge clk);
        check("busy_last_cycle", int'(tx_busy), 1);
        @(negedge clk);
        check("busy_end", int'(tx_busy), 0);
        check("idle_txd", int'(Tx_D), 1);
    endtask

    initial begin : stimulus
        int base;
        int n_rand;
        int gap;
        int guard;
        logic acc;

        reset         = 1'b0;
        u_if.tx_valid = 1'b0;
        u_if.tx_data  = '0;

        // Reset state
        repeat (3) @(negedge clk);
        check("reset_txd", int'(Tx_D), 1);
        check("reset_ready", int'(u_if.tx_ready), 1);
        check("reset_busy", int'(tx_busy), 0);
        check("reset_count", int'(fifo_count), 0);
        reset = 1'b1;
        repeat (20) @(negedge clk);
        check("idle_after_reset", int'(Tx_D), 1);

        // Single frame, then parity corner bytes
        send_single(8'hA5);
        send_single(8'h07);
        send_single(8'h00);
        send_single(8'hFF);

        // Burst of six into a four-deep FIFO: sixth byte is dropped
        wait_idle();
        base = frames_rx;
        for (int i = 1; i <= 6; i++) begin
            u_if.tx_valid = 1'b1;
            u_if.tx_data  = 8'(i);
            check("burst_ready", int'(u_if.tx_ready), (i < 6) ? 1 : 0);
            @(negedge clk);
        end
        u_if.tx_valid = 1'b0;
        check("burst_count", int'(fifo_count), 4);
        check("burst_full_ready", int'(u_if.tx_ready), 0);
        wait_idle();
        check("burst_frames", frames_rx - base, 5);

        // Reset in the middle of data bit 3 with two bytes still queued
        wait_idle();
        base = frames_rx;
        foreach (sb_data[i]) ;
        for (int i = 0; i < 3; i++) begin
            u_if.tx_valid = 1'b1;
            u_if.tx_data  = (i == 0) ? 8'h3C : 8'(8'h11 * i);
            @(negedge clk);
        end
        u_if.tx_valid = 1'b0;
        check("abort_queued", int'(fifo_count), 2);
        repeat (4 * c_CPB + c_CPB / 2 - 1) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("abort_txd", int'(Tx_D), 1);
        check("abort_count", int'(fifo_count), 0);
        check("abort_busy", int'(tx_busy), 0);
        check("abort_ready", int'(u_if.tx_ready), 1);
        reset = 1'b1;
        repeat (3 * c_FRAME_CYC) @(negedge clk);
        check("abort_line_idle", int'(Tx_D), 1);
        check("abort_no_frame", frames_rx - base, 0);

        // Randomised traffic with random gaps, including back-to-back pushes
        base   = frames_rx;
        n_rand = 24;
        for (int i = 0; i < n_rand; i++) begin
            gap = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 200)) : int'($urandom_range(0, 2));
            repeat (gap) @(negedge clk);
            u_if.tx_valid = 1'b1;
            u_if.tx_data  = 8'($urandom);
            guard = 0;
            do begin
                acc = u_if.tx_ready;
                @(negedge clk);
                guard++;
            end while (!acc && guard < 5000);
            if (!acc) check("push_timeout", 1, 0);
            u_if.tx_valid = 1'b0;
        end
        wait_idle();
        repeat (2) @(negedge clk);
        check("random_frames", frames_rx - base, n_rand);
        check("scoreboard_drain", sb_data.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Hard bound on run length
    initial begin : watchdog
        #600000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
